operand_issue: RTL and testbench

OPERAND_ISSUE -- requirements
Module: operand_issue

---
 rtl/operand_issue.sv | 115 +++++++++++
 tb/tb_operand_issue.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_issue.sv
// Three-state operand issue stage: reads two sources from a small register file, holds them
// on the external ALU for two cycles, then writes back the ALU result and flags.
module operand_issue #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic             instr_op,
    input  logic [AW-1:0]    instr_rd,
    input  logic [AW-1:0]    instr_rs1,
    input  logic [AW-1:0]    instr_rs2,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_op,
    input  logic [WIDTH-1:0] alu_c,
    input  logic             alu_zf,
    input  logic             alu_sf,
    input  logic             alu_of,
    output logic             done,
    output logic             zf,
    output logic             sf,
    output logic             of,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    localparam int unsigned Depth = 2 ** AW;

    typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] rf_q [Depth];
    logic [WIDTH-1:0] alu_a_q, alu_b_q;
    logic             alu_op_q;
    logic [AW-1:0]    rd_q;
    logic             zf_q, sf_q, of_q;
    logic             accept;

    // A load in IDLE takes priority over an offered instruction.
    assign instr_ready = (state_q == StIdle) && !ld_en;
    assign accept      = instr_valid && instr_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StExec;
            StExec:  state_d = StWb;
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= 1'b0;
            rd_q     <= '0;
        end else if (accept) begin
            alu_a_q  <= rf_q[instr_rs1];
            alu_b_q  <= rf_q[instr_rs2];
            alu_op_q <= instr_op;
            rd_q     <= instr_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                rf_q[i] <= '0;
            end
        end else if (state_q == StIdle && ld_en) begin
            rf_q[ld_addr] <= ld_data;
        end else if (state_q == StWb) begin
            rf_q[rd_q] <= alu_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zf_q <= 1'b0;
            sf_q <= 1'b0;
            of_q <= 1'b0;
        end else if (state_q == StWb) begin
            zf_q <= alu_zf;
            sf_q <= alu_sf;
            of_q <= alu_of;
        end
    end

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_op   = alu_op_q;
    assign done     = (state_q == StWb);
    assign zf       = zf_q;
    assign sf       = sf_q;
    assign of       = of_q;
    assign dbg_data = rf_q[dbg_addr];

endmodule

// File: tb/tb_operand_issue.sv
// Directed bench for operand_issue with a behavioural ALU (combinational result,
// flags registered one clock after the operands).
module tb_operand_issue;

    localparam int unsigned WIDTH = 9;
    localparam int unsigned AW    = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ld_en;
    logic [AW-1:0]    ld_addr;
    logic [WIDTH-1:0] ld_data;
    logic             instr_valid;
    logic             instr_ready;
    logic             instr_op;
    logic [AW-1:0]    instr_rd, instr_rs1, instr_rs2;
    logic [WIDTH-1:0] alu_a, alu_b, alu_c;
    logic             alu_op;
    logic             alu_zf, alu_sf, alu_of;
    logic             done, zf, sf, of;
    logic [AW-1:0]    dbg_addr;
    logic [WIDTH-1:0] dbg_data;

    int n_checks = 0;
    int n_errors = 0;

    operand_issue #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_rs1   (instr_rs1),
        .instr_rs2   (instr_rs2),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_c       (alu_c),
        .alu_zf      (alu_zf),
        .alu_sf      (alu_sf),
        .alu_of      (alu_of),
        .done        (done),
        .zf          (zf),
        .sf          (sf),
        .of          (of),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    // External ALU model.
    logic ovf_c;
    assign alu_c = alu_op ? (alu_a - alu_b) : (alu_a + alu_b);
    assign ovf_c = alu_op ? ((alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (alu_c[WIDTH-1] != alu_a[WIDTH-1]))
                          : ((alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (alu_c[WIDTH-1] != alu_a[WIDTH-1]));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_zf <= 1'b0;
            alu_sf <= 1'b0;
            alu_of <= 1'b0;
        end else begin
            alu_zf <= (alu_c == '0);
            alu_sf <= alu_c[WIDTH-1];
            alu_of <= ovf_c;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [AW-1:0] addr, input logic [WIDTH-1:0] data);
        ld_en   = 1'b1;
        ld_addr = addr;
        ld_data = data;
        tick();
        ld_en   = 1'b0;
    endtask

    // Drives one instruction from IDLE through writeback; noise drives ld_en during EXEC/WB.
    task automatic issue(input logic op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                         input logic [AW-1:0] rs2, input logic [WIDTH-1:0] ea,
                         input logic [WIDTH-1:0] eb, input logic noise);
        instr_valid = 1'b1;
        instr_op    = op;
        instr_rd    = rd;
        instr_rs1   = rs1;
        instr_rs2   = rs2;
        #1;
        check("accept_ready", 32'(instr_ready), 32'd1);
        tick();
        instr_valid = 1'b0;
        if (noise) begin
            ld_en   = 1'b1;
            ld_addr = rs1;
            ld_data = '1;
        end
        #1;
        check("exec_ready", 32'(instr_ready), 32'd0);
        check("exec_done", 32'(done), 32'd0);
        check("exec_a", 32'(alu_a), 32'(ea));
        check("exec_b", 32'(alu_b), 32'(eb));
        check("exec_op", 32'(alu_op), 32'(op));
        tick();
        check("wb_done", 32'(done), 32'd1);
        check("wb_ready", 32'(instr_ready), 32'd0);
        check("wb_a", 32'(alu_a), 32'(ea));
        check("wb_b", 32'(alu_b), 32'(eb));
        check("wb_op", 32'(alu_op), 32'(op));
        tick();
        ld_en = 1'b0;
        check("post_done", 32'(done), 32'd0);
    endtask

    task automatic check_reg(input string tag, input logic [AW-1:0] addr,
                             input logic [WIDTH-1:0] exp);
        dbg_addr = addr;
        #1;
        check(tag, 32'(dbg_data), 32'(exp));
    endtask

    task automatic check_flags(input string tag, input logic ez, input logic es, input logic eo);
        check(tag, {29'd0, zf, sf, of}, {29'd0, ez, es, eo});
    endtask

    logic [5:0] rdy_seen;

    initial begin
        rst_n       = 1'b0;
        ld_en       = 1'b0;
        ld_addr     = '0;
        ld_data     = '0;
        instr_valid = 1'b0;
        instr_op    = 1'b0;
        instr_rd    = '0;
        instr_rs1   = '0;
        instr_rs2   = '0;
        dbg_addr    = '0;

        #3;
        check("rst_done", 32'(done), 32'd0);
        check("rst_alu", {alu_op, 7'd0, 7'(alu_a), 9'(alu_b)}, 32'd0);
        check_flags("rst_flags", 1'b0, 1'b0, 1'b0);
        check_reg("rst_r0", 3'd0, 9'd0);
        #9;
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", 32'(instr_ready), 32'd1);

        // add r3 = r1 + r2
        load(3'd1, 9'd100);
        load(3'd2, 9'd27);
        issue(1'b0, 3'd3, 3'd1, 3'd2, 9'd100, 9'd27, 1'b0);
        check_reg("add_r3", 3'd3, 9'd127);
        check_flags("add_flags", 1'b0, 1'b0, 1'b0);

        // sub r4 = r1 - r1
        issue(1'b1, 3'd4, 3'd1, 3'd1, 9'd100, 9'd100, 1'b0);
        check_reg("sub_r4", 3'd4, 9'd0);
        check_flags("sub_flags", 1'b1, 1'b0, 1'b0);

        // add r1 = r1 + r2 with signed overflow; rd aliases rs1
        load(3'd1, 9'd200);
        load(3'd2, 9'd100);
        check_flags("flags_hold_ld", 1'b1, 1'b0, 1'b0);
        issue(1'b0, 3'd1, 3'd1, 3'd2, 9'd200, 9'd100, 1'b0);
        check_reg("ovf_r1", 3'd1, 9'h12C);
        check_flags("ovf_flags", 1'b0, 1'b1, 1'b1);

        // loads during EXEC/WB are ignored
        issue(1'b0, 3'd6, 3'd2, 3'd2, 9'd100, 9'd100, 1'b1);
        check_reg("noise_r2", 3'd2, 9'd100);
        check_reg("noise_r6", 3'd6, 9'd200);
        check_flags("noise_flags", 1'b0, 1'b0, 1'b0);

        // instr_valid held for 6 cycles
        instr_valid = 1'b1;
        instr_op    = 1'b0;
        instr_rd    = 3'd7;
        instr_rs1   = 3'd0;
        instr_rs2   = 3'd0;
        for (int i = 0; i < 6; i++) begin
            rdy_seen[i] = instr_ready;
            tick();
        end
        instr_valid = 1'b0;
        check("hold_pattern", 32'(rdy_seen), 32'b001001);
        check_reg("hold_r2_kept", 3'd2, 9'd100);

        // load and instruction together in IDLE
        instr_valid = 1'b1;
        instr_op    = 1'b1;
        instr_rd    = 3'd0;
        instr_rs1   = 3'd5;
        instr_rs2   = 3'd2;
        ld_en       = 1'b1;
        ld_addr     = 3'd5;
        ld_data     = 9'd7;
        #1;
        check("ldv_ready", 32'(instr_ready), 32'd0);
        tick();
        ld_en = 1'b0;
        #1;
        check("ldv_not_acc", 32'(instr_ready), 32'd1);
        check_reg("ldv_r5", 3'd5, 9'd7);
        issue(1'b1, 3'd0, 3'd5, 3'd2, 9'd7, 9'd100, 1'b0);
        check_reg("ldv_r0", 3'd0, 9'h1A3);
        check_flags("ldv_flags", 1'b0, 1'b1, 1'b0);

        // reset during EXEC aborts the instruction
        load(3'd3, 9'd11);
        instr_valid = 1'b1;
        instr_op    = 1'b0;
        instr_rd    = 3'd4;
        instr_rs1   = 3'd3;
        instr_rs2   = 3'd3;
        tick();
        instr_valid = 1'b0;
        check("abort_exec_a", 32'(alu_a), 32'd11);
        rst_n = 1'b0;
        #1;
        check("abort_alu", {alu_op, 7'd0, 7'(alu_a), 9'(alu_b)}, 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check_flags("abort_flags", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("abort_no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        tick();
        check("abort_ready", 32'(instr_ready), 32'd1);
        check("abort_done_after", 32'(done), 32'd0);
        check_reg("abort_r4", 3'd4, 9'd0);
        check_reg("abort_r3", 3'd3, 9'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
